// File: rtl/fraction_normalizer4_if.sv
// fraction_normalizer4_if
//   Groups the multiplier-side capture signals and the downstream result
//   handshake of fraction_normalizer4.
//   Ports carried:
//     Done    - multiplier done flag (level)
//     Product - 7-bit two's-complement fraction, value = Product/64
//     Ready   - downstream accepts the result when Valid & Ready at an edge
//     Mant    - 4-bit rounded mantissa, value = Mant/8
//     Exp     - left-shift count 0..6, result = Mant/8 * 2^-Exp
//     Valid   - result available
//     Sat     - rounding saturated (qualified by Valid)
//     Busy    - normalizer is not idle
//     Lost    - sticky: a start arrived while busy
//   master: the producer/consumer side (drives Done, Product, Ready).
//   slave : the normalizer itself.
interface fraction_normalizer4_if;
  logic       Done;
  logic [6:0] Product;
  logic       Ready;
  logic [3:0] Mant;
  logic [2:0] Exp;
  logic       Valid;
  logic       Sat;
  logic       Busy;
  logic       Lost;

  modport master (
    output Done, Product, Ready,
    input  Mant, Exp, Valid, Sat, Busy, Lost
  );

  modport slave (
    input  Done, Product, Ready,
    output Mant, Exp, Valid, Sat, Busy, Lost
  );
endinterface

// File: rtl/fraction_normalizer4.sv
// fraction_normalizer4
//   Captures the 7-bit product of the 4-bit fraction multiplier on a rising
//   edge of Done, normalizes it with one left shift per cycle while counting
//   the shifts, rounds to a 4-bit saturating mantissa and holds the result
//   under a Valid/Ready handshake.
//   Ports:
//     CLK - clock, rising edge
//     Rst - synchronous, active-high reset
//     bus - fraction_normalizer4_if.slave (Done, Product, Ready in;
//           Mant, Exp, Valid, Sat, Busy, Lost out; all outputs registered)
module fraction_normalizer4 (
  input  logic                   CLK,
  input  logic                   Rst,
  fraction_normalizer4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state, state_d;
  logic [6:0] r, r_d;
  logic [2:0] cnt, cnt_d;
  logic [3:0] mant_q, mant_d;
  logic [2:0] exp_q, exp_d;
  logic       sat_q, sat_d;
  logic       valid_q, busy_q, lost_q;
  logic       done_prev;

  logic       start;
  logic       norm_done;
  logic       sat_cond;
  logic [3:0] round_sum;

  assign start = bus.Done & ~done_prev;

  // Normalization stops on a zero value, once the sign bit and the bit below
  // it differ (the value is normalized), or after the maximum of six shifts.
  assign norm_done = (r == 7'd0) || (r[6] != r[5]) || (cnt == 3'd6);

  // Round half up on the first discarded bit. Only +0.111 with a set round
  // bit can wrap past the largest positive mantissa; negative normalized
  // values (1000..1011) always stay in range.
  assign round_sum = r[6:3] + {3'b000, r[2]};
  assign sat_cond  = (r[6:3] == 4'b0111) && r[2];

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state;
    r_d     = r;
    cnt_d   = cnt;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sat_d   = sat_q;

    case (state)
      IDLE: begin
        if (start) begin
          r_d     = bus.Product;
          cnt_d   = 3'd0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (norm_done) begin
          state_d = ROUND;
        end else begin
          r_d   = {r[5:0], 1'b0};
          cnt_d = cnt + 3'd1;
        end
      end
      ROUND: begin
        if (sat_cond) begin
          mant_d = 4'b0111;
          sat_d  = 1'b1;
        end else begin
          mant_d = round_sum;
          sat_d  = 1'b0;
        end
        exp_d   = cnt;
        state_d = HOLD;
      end
      HOLD: begin
        // A start coinciding with acceptance is dropped: capture only in IDLE.
        if (bus.Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      r         <= 7'd0;
      cnt       <= 3'd0;
      mant_q    <= 4'd0;
      exp_q     <= 3'd0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      lost_q    <= 1'b0;
      // Reset high so a Done held through reset is not seen as a rising edge.
      done_prev <= 1'b1;
    end else begin
      r         <= r_d;
      cnt       <= cnt_d;
      mant_q    <= mant_d;
      exp_q     <= exp_d;
      sat_q     <= sat_d;
      valid_q   <= (state_d == HOLD);
      busy_q    <= (state_d != IDLE);
      lost_q    <= lost_q | (start & (state != IDLE));
      done_prev <= bus.Done;
    end
  end

  assign bus.Mant  = mant_q;
  assign bus.Exp   = exp_q;
  assign bus.Sat   = sat_q;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;
  assign bus.Lost  = lost_q;

endmodule
